// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the MIPS-lite hazard controller: opcodes, link register,
// FSM encodings and scoreboard geometry.
package hazard_ctrl_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam int LINK_REG = 31;

    // Scoreboard geometry: one entry per downstream stage, EX youngest.
    localparam int SB_DEST_W  = 5;
    localparam int SB_ENTRIES = 3;
    localparam int SB_EX      = 0;
    localparam int SB_MEM     = 1;
    localparam int SB_WB      = 2;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Shadow scoreboard of in-flight destinations (EX/MEM/WB) and the EX load-use compare.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = SB_DEST_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  ex_kill,
    input  logic                  id_dest_vld,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    output logic                  load_match
);

    logic [SB_ENTRIES-1:0]                 vld;
    logic [SB_ENTRIES-1:0]                 ld;
    logic [SB_ENTRIES-1:0][REG_ADDR_W-1:0] dst;

    logic                  nxt_vld;
    logic [REG_ADDR_W-1:0] nxt_dst;
    logic                  wb_unused;

    // $0 is hardwired, so it never becomes a tracked destination.
    assign nxt_vld = id_dest_vld & ~ex_kill & (id_dest != '0);
    assign nxt_dst = nxt_vld ? id_dest : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            ld  <= '0;
            dst <= '0;
        end else if (!freeze) begin
            vld <= {vld[SB_ENTRIES-2:0], nxt_vld};
            ld  <= {ld[SB_ENTRIES-2:0], nxt_vld & id_is_load};
            dst <= {dst[SB_ENTRIES-2:0], nxt_dst};
        end
    end

    // Only an EX-stage load can stall; MEM/WB results are bypassed.
    assign load_match = vld[SB_EX] & ld[SB_EX] &
                        ((id_use_rs & (dst[SB_EX] == id_rs)) |
                         (id_use_rt & (dst[SB_EX] == id_rt)));

    // The WB entry retires off the end of the shift register.
    assign wb_unused = ^{vld[SB_WB], ld[SB_WB], dst[SB_WB]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, dmem freeze, branch/JAL flushes and
// saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       id_op,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_busy,
    output logic                  stall,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  freeze,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    state_e state_q, state_d;

    logic                  dec_dest_vld;
    logic                  dec_is_load;
    logic [REG_ADDR_W-1:0] dec_dest;
    logic                  dec_use_rs;
    logic                  dec_use_rt;
    logic                  load_match;

    always_comb begin
        dec_dest_vld = 1'b0;
        dec_is_load  = 1'b0;
        dec_dest     = '0;
        dec_use_rs   = 1'b0;
        dec_use_rt   = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                dec_dest_vld = 1'b1;
                dec_dest     = id_rd;
                dec_use_rs   = 1'b1;
                dec_use_rt   = 1'b1;
            end
            OP_ORI, OP_XORI: begin
                dec_dest_vld = 1'b1;
                dec_dest     = id_rt;
                dec_use_rs   = 1'b1;
            end
            OP_LW: begin
                dec_dest_vld = 1'b1;
                dec_dest     = id_rt;
                dec_is_load  = 1'b1;
                dec_use_rs   = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                dec_use_rs   = 1'b1;
                dec_use_rt   = 1'b1;
            end
            OP_JAL: begin
                dec_dest_vld = 1'b1;
                dec_dest     = REG_ADDR_W'(LINK_REG);
            end
            default: ;
        endcase
    end

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .ex_kill     (stall | idex_flush),
        .id_dest_vld (dec_dest_vld),
        .id_is_load  (dec_is_load),
        .id_dest     (dec_dest),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (dec_use_rs),
        .id_use_rt   (dec_use_rt),
        .load_match  (load_match)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Priority: dmem_busy > branch > load-use > JAL > normal.
    // The cycle dmem_busy drops is handled as RUN so a load still sitting in
    // EX after the freeze is caught before its consumer advances.
    always_comb begin
        state_d    = ST_RUN;
        stall      = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        freeze     = 1'b0;

        if (dmem_busy) begin
            freeze  = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_match) begin
            stall   = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (id_op == OP_JAL) begin
            ifid_flush = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (dmem_busy)  state_d = ST_MEM_WAIT;
                else if (stall) state_d = ST_LOAD_STALL;
            end
            ST_LOAD_STALL, ST_MEM_WAIT: begin
                if (dmem_busy)  state_d = ST_MEM_WAIT;
            end
            default: state_d = ST_RUN;
        endcase

        if (rst) begin
            stall      = 1'b1;
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            freeze     = 1'b0;
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stall | freeze) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != '1))       flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a stage-level pipeline model and a 4-bit counter twin.
module tb_hazard_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_XORI  = 6'b001110;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_JAL   = 6'b000011;
    localparam logic [5:0] T_NOP   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_branch_taken, dmem_busy;

    logic        stall, pc_we, ifid_we, ifid_flush, idex_flush, freeze;
    logic [31:0] stall_cnt, flush_cnt;
    logic        stall4, pc_we4, ifid_we4, ifid_flush4, idex_flush4, freeze4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4), .REG_ADDR_W(5)) dut4 (
        .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .stall(stall4), .pc_we(pc_we4), .ifid_we(ifid_we4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .freeze(freeze4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    // Model: what occupies each downstream stage, plus raw event counts.
    bit m_known = 0;
    bit m_v[3];
    bit m_l[3];
    int m_d[3];
    int m_sc, m_fc;

    // Outputs sampled in the most recent step, for hand-pinned checks.
    bit s_stall, s_pc_we, s_ifid_flush, s_idex_flush, s_freeze;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic step(input bit r, input logic [5:0] op, input int rs, input int rt,
                        input int rd, input bit br, input bit busy);
        bit dv, ld, urs, urt, luse;
        int d;
        bit e_st, e_pc, e_ifwe, e_iff, e_idf, e_fz;
        rst = r; id_op = op; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
        ex_branch_taken = br; dmem_busy = busy;
        @(negedge clk);

        dv = 0; ld = 0; urs = 0; urt = 0; d = 0;
        case (op)
            T_RTYPE:       begin dv = 1; d = rd; urs = 1; urt = 1; end
            T_ORI, T_XORI: begin dv = 1; d = rt; urs = 1; end
            T_LW:          begin dv = 1; d = rt; urs = 1; ld = 1; end
            T_SW, T_BEQ:   begin urs = 1; urt = 1; end
            T_JAL:         begin dv = 1; d = 31; end
            default: ;
        endcase
        if (d == 0) dv = 0;
        luse = m_known && m_v[0] && m_l[0] && ((urs && m_d[0] == rs) || (urt && m_d[0] == rt));

        e_st = 0; e_pc = 1; e_ifwe = 1; e_iff = 0; e_idf = 0; e_fz = 0;
        if (r) begin
            e_st = 1; e_pc = 0; e_ifwe = 0; e_iff = 1; e_idf = 1;
        end else if (busy) begin
            e_fz = 1; e_pc = 0; e_ifwe = 0;
        end else if (br) begin
            e_iff = 1; e_idf = 1;
        end else if (luse) begin
            e_st = 1; e_pc = 0; e_ifwe = 0;
        end else if (op == T_JAL) begin
            e_iff = 1;
        end

        chk("stall", stall, e_st);            chk("stall4", stall4, e_st);
        chk("pc_we", pc_we, e_pc);            chk("pc_we4", pc_we4, e_pc);
        chk("ifid_we", ifid_we, e_ifwe);      chk("ifid_we4", ifid_we4, e_ifwe);
        chk("ifid_flush", ifid_flush, e_iff); chk("ifid_flush4", ifid_flush4, e_iff);
        chk("idex_flush", idex_flush, e_idf); chk("idex_flush4", idex_flush4, e_idf);
        chk("freeze", freeze, e_fz);          chk("freeze4", freeze4, e_fz);
        if (m_known) begin
            chk("stall_cnt", stall_cnt, m_sc);
            chk("flush_cnt", flush_cnt, m_fc);
            chk("stall_cnt4", stall_cnt4, sat(m_sc, 4));
            chk("flush_cnt4", flush_cnt4, sat(m_fc, 4));
        end
        s_stall = stall; s_pc_we = pc_we; s_ifid_flush = ifid_flush;
        s_idex_flush = idex_flush; s_freeze = freeze;

        if (r) begin
            m_known = 1;
            for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_l[i] = 0; m_d[i] = 0; end
            m_sc = 0; m_fc = 0;
        end else if (m_known) begin
            if (!e_fz) begin
                for (int i = 2; i > 0; i--) begin
                    m_v[i] = m_v[i-1]; m_l[i] = m_l[i-1]; m_d[i] = m_d[i-1];
                end
                if (e_st || e_idf || !dv) begin m_v[0] = 0; m_l[0] = 0; m_d[0] = 0; end
                else begin m_v[0] = 1; m_l[0] = ld; m_d[0] = d; end
            end
            if (e_st || e_fz) m_sc++;
            if (e_iff) m_fc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, T_NOP, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; id_op = T_NOP; id_rs = 0; id_rt = 0; id_rd = 0;
        ex_branch_taken = 0; dmem_busy = 0;

        // Reset outputs and clear.
        step(1, T_NOP, 0, 0, 0, 0, 0);
        step(1, T_NOP, 0, 0, 0, 0, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_pin", s_ifid_flush, 1);

        // LW $2,0($1); ADD $3,$2,$4 -> one stall cycle.
        step(0, T_LW, 1, 2, 0, 0, 0);
        step(0, T_RTYPE, 2, 4, 3, 0, 0);
        chk("lu_stall_pin", s_stall, 1);
        chk("lu_pcwe_pin", s_pc_we, 0);
        step(0, T_RTYPE, 2, 4, 3, 0, 0);
        chk("lu_once_pin", s_stall, 0);
        nop(3);
        chk("lu_cnt_pin", stall_cnt, 1);

        // LW $2; ORI $5,$2,1 with dmem_busy for 3 cycles after the stall.
        step(1, T_NOP, 0, 0, 0, 0, 0);
        step(0, T_LW, 1, 2, 0, 0, 0);
        step(0, T_ORI, 2, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, T_ORI, 2, 5, 0, 0, 1);
        chk("busy_freeze_pin", s_freeze, 1);
        chk("busy_noflush_pin", s_ifid_flush, 0);
        step(0, T_ORI, 2, 5, 0, 0, 0);
        chk("busy_release_pin", s_freeze, 0);
        nop(2);
        chk("busy_cnt_pin", stall_cnt, 4);

        // Taken branch overrides a pending load-use stall.
        step(1, T_NOP, 0, 0, 0, 0, 0);
        step(0, T_LW, 1, 2, 0, 0, 0);
        step(0, T_RTYPE, 2, 4, 3, 1, 0);
        chk("br_stall_pin", s_stall, 0);
        chk("br_idex_pin", s_idex_flush, 1);
        step(0, T_RTYPE, 2, 4, 3, 0, 0);
        chk("br_after_pin", s_stall, 0);
        chk("br_flush_cnt_pin", flush_cnt, 1);
        nop(2);

        // JAL then ADDU $6,$31,$0 -> flush only, no stall.
        step(1, T_NOP, 0, 0, 0, 0, 0);
        step(0, T_JAL, 0, 0, 0, 0, 0);
        chk("jal_flush_pin", s_ifid_flush, 1);
        chk("jal_idex_pin", s_idex_flush, 0);
        step(0, T_RTYPE, 31, 0, 6, 0, 0);
        chk("jal_nostall_pin", s_stall, 0);
        nop(3);
        chk("jal_cnt_pin", flush_cnt, 1);

        // Load to $0 never creates a hazard; other opcodes mixed in.
        step(0, T_LW, 1, 0, 0, 0, 0);
        step(0, T_RTYPE, 0, 0, 7, 0, 0);
        chk("zero_nostall_pin", s_stall, 0);
        step(0, T_LW, 3, 9, 0, 0, 0);
        step(0, T_SW, 4, 9, 0, 0, 0);
        step(0, T_XORI, 9, 10, 0, 0, 0);
        step(0, T_LW, 3, 11, 0, 0, 0);
        step(0, T_BEQ, 12, 11, 0, 0, 0);
        step(0, T_BEQ, 12, 11, 0, 0, 0);
        nop(2);

        // Reset during a load stall and during a memory wait.
        step(0, T_LW, 1, 2, 0, 0, 0);
        step(0, T_RTYPE, 2, 4, 3, 0, 0);
        step(1, T_RTYPE, 2, 4, 3, 0, 0);
        step(0, T_RTYPE, 2, 4, 3, 0, 0);
        chk("rst_ls_nostall_pin", s_stall, 0);
        chk("rst_ls_cnt_pin", stall_cnt, 0);
        step(0, T_LW, 1, 2, 0, 0, 1);
        step(0, T_LW, 1, 2, 0, 0, 1);
        step(1, T_LW, 1, 2, 0, 0, 1);
        step(0, T_NOP, 0, 0, 0, 0, 0);
        chk("rst_mw_pcwe_pin", s_pc_we, 1);
        chk("rst_mw_freeze_pin", s_freeze, 0);
        nop(2);

        // Counter saturation on the 4-bit twin.
        step(1, T_NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, T_NOP, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(0, T_NOP, 0, 0, 0, 1, 0);
        nop(1);
        chk("sat_stall4_pin", stall_cnt4, 15);
        chk("sat_stall32_pin", stall_cnt, 20);
        chk("sat_flush4_pin", flush_cnt4, 15);
        chk("sat_flush32_pin", flush_cnt, 17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS-lite core (IF/ID/EX/MEM/WB).
- Watches the opcode and register fields in ID and keeps its own shadow scoreboard of in-flight destinations.
- Accepts branch resolution from EX and a data-memory busy handshake.
- Produces `stall`, which the decode controller consumes to zero its control word, plus PC/IF-ID write enables, flushes and stall/flush performance counters.

Parameters:
- CNT_W, 32, width of each saturating performance counter.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- id_op  in  6  opcode of the instruction in ID.
- id_rs  in  5  rs field in ID.
- id_rt  in  5  rt field in ID.
- id_rd  in  5  rd field in ID.
- ex_branch_taken  in  1  BEQ in EX resolved taken this cycle.
- dmem_busy  in  1  data memory not ready; the whole pipeline must hold.
- stall  out  1  1 = decode controller emits the all-zero control word (bubble into ID/EX).
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to NOP on the next edge.
- idex_flush  out  1  clear ID/EX to NOP on the next edge.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  cycles with stall=1 or freeze=1, saturating.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1, saturating.

Behaviour:
- Opcodes:
  - R_TYPE 000000: dest rd; src rs, rt.
  - ORI 001101 and XORI 001110: dest rt; src rs.
  - LW 100011: dest rt; src rs; is_load.
  - SW 101011: no dest; src rs, rt.
  - BEQ 000100: no dest; src rs, rt.
  - JAL 000011: dest 31; no src.
  - Any other opcode: treated as NOP (no dest, no src).
- Destination 0 is never recorded as valid.
- Scoreboard:
  - Three registered entries EX, MEM, WB, each {valid, is_load, dest}.
  - Each enabled cycle: WB<=MEM, MEM<=EX, EX<=decoded ID entry.
  - EX<=empty when the ID instruction is bubbled (stall) or flushed.
  - All entries hold while freeze=1.
- Load-use hazard:
  - Condition: EX.valid & EX.is_load & EX.dest matches an ID source.
  - Response: stall=1, pc_we=0, ifid_we=0 for exactly 1 cycle.
  - MEM and WB dependencies are covered by forwarding/register-file bypass and never stall.
- FSM states RUN, LOAD_STALL, MEM_WAIT; reset state RUN.
  - RUN -> MEM_WAIT when dmem_busy=1.
  - RUN -> LOAD_STALL when a load-use hazard exists.
  - LOAD_STALL -> RUN unconditionally after 1 cycle, unless dmem_busy=1 -> MEM_WAIT.
  - MEM_WAIT -> RUN on the first cycle dmem_busy=0.
  - MEM_WAIT does not re-evaluate the load-use hazard until back in RUN.
- Output decode by state:
  - MEM_WAIT, and any cycle with dmem_busy=1: freeze=1, pc_we=0, ifid_we=0, stall=0, no flush.
  - LOAD_STALL: stall=1, pc_we=0, ifid_we=0.
  - RUN with no event: pc_we=1, ifid_we=1, all other outputs 0.
- Control hazards, evaluated only when dmem_busy=0:
  - ex_branch_taken=1: ifid_flush=1 and idex_flush=1. pc_we=1 so the target loads. The scoreboard EX entry receives empty. A load-use stall in the same cycle is cancelled and the state stays RUN.
  - id_op=JAL with no branch taken and no load stall: ifid_flush=1 only. JAL itself proceeds and is recorded with dest 31.
- Priority: dmem_busy > ex_branch_taken > load-use > JAL > normal.
- Counters:
  - Increment by 1 per qualifying cycle.
  - Saturate at all-ones; they do not wrap.
- Reset:
  - rst sampled high clears the scoreboard and both counters and forces RUN.
  - While rst=1 the outputs are: stall=1, pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, freeze=0.
  - Reset asserted mid-LOAD_STALL or mid-MEM_WAIT behaves identically; no pending state survives.
- Latency:
  - Hazard outputs are combinational from the current state, scoreboard and inputs, in the same cycle.
  - State, scoreboard and counters update on the rising edge of clk.

Decomposition:
- Shared package (head.v): the OP_* opcode constants (already used by the decode controller), the JAL link register index 31, the FSM state encodings, and the scoreboard entry field widths.
- One sub-module: hazard_scoreboard, which holds the 3-entry shift register, the enable/flush/freeze controls, and the EX-stage load-match compare output.

Test Plan:
- LW $2,0($1) then ADD $3,$2,$4 -> exactly 1 cycle of stall=1, pc_we=0, ifid_we=0; ADD reaches EX 1 cycle later; stall_cnt=1.
- LW $2 then ORI $5,$2,1 with dmem_busy=1 for 3 cycles during LW's MEM -> freeze=1 for 3 cycles with no flush; stall_cnt=4 after the load stall.
- BEQ taken in EX while ID holds ADD dependent on an EX load -> ifid_flush=idex_flush=1 and stall=0 in the same cycle; flush_cnt=1; state stays RUN.
- JAL in ID, then ADDU $6,$31,$0 -> ifid_flush=1 for 1 cycle; no stall, since $31 is forwarded rather than a load.
- LW $0,0($1) followed by use of $0 -> no stall, because dest 0 is never valid.
- rst asserted during LOAD_STALL and during MEM_WAIT -> next cycle is RUN, scoreboard empty, counters 0; a CNT_W=4 variant saturates stall_cnt at 15.
